uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 100 ++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Imported by the transmit-path blocks.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int UART_TX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic push;
    logic pop;
  } fifo_op_t;

  // A push needs room, a pop needs data;
  // both look only at registered flags.
  function automatic fifo_op_t fifo_op(
    input logic s_valid,
    input logic full,
    input logic m_ready,
    input logic empty
  );
    fifo_op_t op;
    op.push = s_valid && !full;
    op.pop  = m_ready && !empty;
    return op;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between producer and UART tx.
// First-word-fall-through, registered flags.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     s_valid_i,
  input  logic [WIDTH-1:0]         s_data_i,
  output logic                     s_ready_o,
  output logic                     m_valid_o,
  output logic [WIDTH-1:0]         m_data_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  fifo_op_t op;

  // Handshakes qualified by registered flags.
  always_comb begin
    op = fifo_op(s_valid_i, full_q,
                 m_ready_i, empty_q);
  end

  // Pointer/counter next state; flush wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (op.push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (op.pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({op.push, op.pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == '0);
  end

  // Control registers; reset beats flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; writes dropped
  // when the same edge clears the FIFO.
  always_ff @(posedge clk_i) begin
    if (op.push && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  assign s_ready_o = !full_q;
  assign m_valid_o = !empty_q;
  assign m_data_o  = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule
